// File: rtl/picosoc_timer.sv
// picosoc_timer: memory-mapped down-counting timer on the PicoSoC iomem bus.
// Decodes a 32-byte window at BASE_ADDR and drives a level IRQ output.
// Optional feature macro: PICOSOC_TIMER_PRESCALER_EN adds a 16-bit tick
// prescaler. Without it, PRESCALE reads 0 and the counter ticks every cycle
// while EN is set.
module picosoc_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_RELOAD   = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_irq;
  logic        r_en;
  logic        r_auto;
  logic        r_ie;
  logic        r_mf;
  logic [31:0] r_count;
  logic [31:0] r_reload;

  logic        w_sel;
  logic        w_acc;
  logic        w_wr;
  logic [2:0]  w_off;
  logic        w_wrCtrl;
  logic        w_wrCount;
  logic        w_wrReload;
  logic        w_clrMf;
  logic        w_tick;
  logic        w_match;
  logic [31:0] w_countNext;
  logic [31:0] w_rdMux;
  logic [31:0] w_prescaleRd;
  logic        w_unused;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] byteMerge(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? newVal[8*i +: 8] : oldVal[8*i +: 8];
    end
    return res;
  endfunction

  // An access is accepted only in the cycle before ready rises, so a held
  // valid never commits the same write twice.
  assign w_sel      = iomem_valid && (iomem_addr[31:5] == BASE_ADDR[31:5]);
  assign w_acc      = w_sel && !r_ready;
  assign w_wr       = w_acc && (iomem_wstrb != 4'b0000);
  assign w_off      = iomem_addr[4:2];
  assign w_wrCtrl   = w_wr && (w_off == OFF_CTRL) && iomem_wstrb[0];
  assign w_wrCount  = w_wr && (w_off == OFF_COUNT);
  assign w_wrReload = w_wr && (w_off == OFF_RELOAD);
  assign w_clrMf    = w_wr && (w_off == OFF_STATUS) && iomem_wstrb[0] && iomem_wdata[0];
  assign w_match    = w_tick && (r_count == 32'd0);
  assign w_unused   = &{1'b0, iomem_addr[1:0]};

`ifdef PICOSOC_TIMER_PRESCALER_EN
  logic [15:0] r_prescale;
  logic [15:0] r_pcnt;
  logic        w_wrPrescale;

  assign w_wrPrescale = w_wr && (w_off == OFF_PRESCALE);
  assign w_tick       = r_en && (r_pcnt == r_prescale);
  assign w_prescaleRd = {16'd0, r_prescale};

  // Prescaler: pcnt runs while enabled and restarts from 0 after each tick;
  // a PRESCALE write leaves pcnt alone, so it may wrap before matching.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pcnt     <= 16'd0;
      r_prescale <= 16'd0;
    end else begin
      if (!r_en)       r_pcnt <= 16'd0;
      else if (w_tick) r_pcnt <= 16'd0;
      else             r_pcnt <= r_pcnt + 16'd1;
      if (w_wrPrescale && iomem_wstrb[0]) r_prescale[7:0]  <= iomem_wdata[7:0];
      if (w_wrPrescale && iomem_wstrb[1]) r_prescale[15:8] <= iomem_wdata[15:8];
    end
  end
`else
  assign w_tick       = r_en;
  assign w_prescaleRd = 32'd0;
`endif

  // Next COUNT: tick update first, then CPU-written bytes override it.
  always_comb begin
    w_countNext = r_count;
    if (w_tick) begin
      if (r_count != 32'd0) w_countNext = r_count - 32'd1;
      else if (r_auto)      w_countNext = r_reload;
    end
    if (w_wrCount) w_countNext = byteMerge(w_countNext, iomem_wdata, iomem_wstrb);
  end

  // Read mux over the register window; unmapped offsets read 0.
  always_comb begin
    w_rdMux = 32'd0;
    case (w_off)
      OFF_CTRL:     w_rdMux = {29'd0, r_ie, r_auto, r_en};
      OFF_PRESCALE: w_rdMux = w_prescaleRd;
      OFF_COUNT:    w_rdMux = r_count;
      OFF_RELOAD:   w_rdMux = r_reload;
      OFF_STATUS:   w_rdMux = {31'd0, r_mf};
      default:      w_rdMux = 32'd0;
    endcase
  end

  // Timer state: control bits, counter, reload and the sticky match flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_ie     <= 1'b0;
      r_mf     <= 1'b0;
      r_count  <= 32'd0;
      r_reload <= 32'd0;
    end else begin
      r_count <= w_countNext;
      r_mf    <= w_match | (r_mf & ~w_clrMf);
      if (w_wrCtrl) begin
        r_en   <= iomem_wdata[0];
        r_auto <= iomem_wdata[1];
        r_ie   <= iomem_wdata[2];
      end else if (w_match && !r_auto) begin
        r_en <= 1'b0;
      end
      if (w_wrReload) r_reload <= byteMerge(r_reload, iomem_wdata, iomem_wstrb);
    end
  end

  // Bus response and interrupt are registered; rdata is 0 outside ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
      r_irq   <= 1'b0;
    end else begin
      r_ready <= w_acc;
      r_rdata <= w_acc ? w_rdMux : 32'd0;
      r_irq   <= r_mf & r_ie;
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq         = r_irq;

endmodule

// File: tb/tb_picosoc_timer.sv
// tb_picosoc_timer: scoreboard bench for picosoc_timer with directed vectors.
module tb_picosoc_timer;

  localparam logic [31:0] BASE = 32'h0300_0000;
`ifdef PICOSOC_TIMER_PRESCALER_EN
  localparam bit HAS_PRE = 1'b1;
`else
  localparam bit HAS_PRE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = 4'd0;
  logic [31:0] iomem_addr = 32'd0;
  logic [31:0] iomem_wdata = 32'd0;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       nm;
  } sbEntry_t;
  sbEntry_t sbQ[$];

  picosoc_timer #(.BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Monitor: every ready pulse pops one scoreboard entry and checks it.
  logic prevReady = 1'b0;
  always @(negedge clk) begin
    sbEntry_t e;
    if (resetn) begin
      if (iomem_ready) begin
        vectors++;
        if (prevReady) begin
          miscompares++;
          $display("[TB] FAIL readyWidth: ready high %0d cycles, required 1", 2);
        end
        if (sbQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpectedReady: ready=1 with no access, required 0");
        end else begin
          e = sbQ.pop_front();
          if (e.chk && (iomem_rdata !== e.exp)) begin
            miscompares++;
            $display("[TB] FAIL %s: rdata=0x%08h required 0x%08h", e.nm, iomem_rdata, e.exp);
          end
        end
      end else if (iomem_rdata !== 32'd0) begin
        miscompares++;
        $display("[TB] FAIL idleRdata: rdata=0x%08h required 0x00000000", iomem_rdata);
      end
    end
    prevReady = iomem_ready;
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  // One bus access: commit on the first posedge, valid held one more cycle.
  task automatic applyStimulus(input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d, input bit chk,
                               input logic [31:0] exp, input string nm);
    sbEntry_t e;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    e.chk = chk;
    e.exp = exp;
    e.nm  = nm;
    sbQ.push_back(e);
    @(posedge clk);
    @(posedge clk);
    #1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'd0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [3:0] s, input logic [31:0] d);
    applyStimulus(BASE + {27'd0, off}, s, d, 1'b0, 32'd0, "write");
  endtask

  task automatic rd(input logic [4:0] off, input logic [31:0] exp, input string nm);
    applyStimulus(BASE + {27'd0, off}, 4'd0, 32'd0, 1'b1, exp, nm);
  endtask

  task automatic oneShot(input logic [15:0] p, input logic [31:0] n);
    int mfEdge;
    wr(5'h04, 4'hF, {16'd0, p});
    wr(5'h08, 4'hF, n);
    wr(5'h00, 4'hF, 32'h5);
    mfEdge = (int'(n) + 1) * ((HAS_PRE ? int'(p) : 0) + 1);
    repeat (mfEdge - 1) @(posedge clk);
    #1;
    checkOutput("oneShotIrqEarly", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("oneShotIrq", {31'd0, irq}, 32'd1);
    rd(5'h10, 32'd1, "oneShotMf");
    rd(5'h00, 32'd4, "oneShotCtrl");
    rd(5'h08, 32'd0, "oneShotCount");
    wr(5'h10, 4'h1, 32'd1);
    wr(5'h00, 4'hF, 32'd0);
  endtask

  initial begin
    int readyCnt;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Reset state
    checkOutput("resetIrq", {31'd0, irq}, 32'd0);
    checkOutput("resetReady", {31'd0, iomem_ready}, 32'd0);
    for (int i = 0; i < 8; i++) rd(5'(i * 4), 32'd0, "resetRead");

    // Byte strobes, PRESCALE, reserved offsets
    wr(5'h0C, 4'b0101, 32'hAABB_CCDD);
    rd(5'h0C, 32'h00BB_00DD, "reloadStrobe");
    wr(5'h04, 4'hF, 32'h10);
    rd(5'h04, HAS_PRE ? 32'h10 : 32'h0, "prescaleRead");
    wr(5'h04, 4'hF, 32'h0);
    wr(5'h14, 4'hF, 32'hFFFF_FFFF);
    rd(5'h14, 32'd0, "reservedRead");

    // Unselected address never answers
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0040;
    iomem_wstrb = 4'd0;
    readyCnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (iomem_ready) readyCnt++;
    end
    iomem_valid = 1'b0;
    checkOutput("unselectedReady", readyCnt, 32'd0);

    // One-shot runs
    oneShot(16'd3, 32'd2);
    oneShot(16'd0, 32'd3);

    // Auto-reload: PRESCALE=0, RELOAD=4, COUNT=0, CTRL=7 (commit edge E0)
    wr(5'h04, 4'hF, 32'd0);
    wr(5'h0C, 4'hF, 32'd4);
    wr(5'h08, 4'hF, 32'd0);
    wr(5'h00, 4'hF, 32'h7);
    rd(5'h08, 32'd4, "autoCountA");
    rd(5'h08, 32'd2, "autoCountB");
    rd(5'h08, 32'd0, "autoCountC");
    rd(5'h08, 32'd3, "autoCountD");
    rd(5'h08, 32'd1, "autoCountE");
    rd(5'h08, 32'd4, "autoCountF");
    checkOutput("autoIrqHigh", {31'd0, irq}, 32'd1);
    wr(5'h10, 4'h1, 32'd1);
    checkOutput("autoIrqFall", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("autoIrqStillLow", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("autoIrqPeriod", {31'd0, irq}, 32'd1);

    // STATUS clear colliding with a match (commit at E0+21)
    wr(5'h10, 4'h1, 32'd1);
    @(posedge clk);
    wr(5'h10, 4'h1, 32'd1);
    rd(5'h10, 32'd1, "clearVsMatch");

    // COUNT write on a tick, then stop the timer
    wr(5'h08, 4'hF, 32'h100);
    rd(5'h08, 32'hFF, "countWriteWins");
    wr(5'h00, 4'hF, 32'd0);
    rd(5'h08, 32'hFC, "countAfterStop");
    rd(5'h08, 32'hFC, "countHeld");
    rd(5'h10, 32'd1, "statusAfterStop");

    // Reset asserted mid-transfer
    wr(5'h00, 4'hF, 32'h4);
    checkOutput("preResetIrq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = BASE;
    iomem_wstrb = 4'd0;
    @(posedge clk);
    #2;
    checkOutput("preResetReady", {31'd0, iomem_ready}, 32'd1);
    checkOutput("preResetRdata", iomem_rdata, 32'd4);
    resetn = 1'b0;
    #1;
    checkOutput("asyncResetReady", {31'd0, iomem_ready}, 32'd0);
    checkOutput("asyncResetRdata", iomem_rdata, 32'd0);
    checkOutput("asyncResetIrq", {31'd0, irq}, 32'd0);
    iomem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    rd(5'h00, 32'd0, "postResetCtrl");
    rd(5'h10, 32'd0, "postResetStatus");
    rd(5'h08, 32'd0, "postResetCount");

    repeat (2) @(posedge clk);
    checkOutput("scoreboardDrained", sbQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
